// File: rtl/psram_arbiter_if.sv
// Requester and controller signals shared between the PSRAM arbiter and the
// blocks around it. The arbiter takes the slave view; the requesters and
// controller (or a bench standing in for them) take the master view.
interface psram_arbiter_if #(
  parameter int ADDR_BITS = 23,
  parameter int LEN_BITS  = 8
);
  // VGA line-fetch read port
  logic                 rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [LEN_BITS-1:0]  rd_len;
  logic                 rd_grant;
  logic [7:0]           rd_data;
  logic                 rd_data_valid;
  logic                 rd_done;
  // MCU-bus write port
  logic                 wr_req;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [LEN_BITS-1:0]  wr_len;
  logic [7:0]           wr_data;
  logic                 wr_grant;
  logic                 wr_data_ack;
  logic                 wr_done;
  // PSRAM controller side
  logic                 psram_enable;
  logic                 psram_rw;
  logic [ADDR_BITS-1:0] psram_address;
  logic [7:0]           psram_wdata;
  logic [7:0]           psram_rdata;
  logic                 psram_byte_strobe;
  logic                 psram_busy;

  modport slave (
    input  rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len, wr_data,
           psram_rdata, psram_byte_strobe, psram_busy,
    output rd_grant, rd_data, rd_data_valid, rd_done,
           wr_grant, wr_data_ack, wr_done,
           psram_enable, psram_rw, psram_address, psram_wdata
  );

  modport master (
    output rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len, wr_data,
           psram_rdata, psram_byte_strobe, psram_busy,
    input  rd_grant, rd_data, rd_data_valid, rd_done,
           wr_grant, wr_data_ack, wr_done,
           psram_enable, psram_rw, psram_address, psram_wdata
  );
endinterface

// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of the single PSRAM controller. Reads (VGA line
// fetch) win by default; a pending write is forced through once it has been
// passed over STARVE_LIMIT times in a row. Each burst walks
// IDLE -> ARM -> BURST -> DRAIN, counting bytes on the controller strobe.
module psram_arbiter #(
  parameter int ADDR_BITS    = 23,
  parameter int LEN_BITS     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           sysclk,
  input  logic           sys_reset_n,
  psram_arbiter_if.slave bus
);

  localparam int STARVE_BITS = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ARM, BURST, DRAIN} state_t;

  state_t                 r_state,     w_state;
  logic [STARVE_BITS-1:0] r_starve,    w_starve;
  logic [LEN_BITS-1:0]    r_cnt,       w_cnt;
  logic [LEN_BITS-1:0]    r_len,       w_len;
  logic [ADDR_BITS-1:0]   r_addr,      w_addr;
  logic                   r_dir,       w_dir;       // 1 = write burst
  logic                   r_rd_grant,  w_rd_grant;
  logic                   r_wr_grant,  w_wr_grant;
  logic                   r_enable,    w_enable;
  logic                   r_rw,        w_rw;
  logic [7:0]             r_rd_data,   w_rd_data;
  logic                   r_rd_valid,  w_rd_valid;
  logic                   r_wr_ack,    w_wr_ack;
  logic                   r_rd_done,   w_rd_done;
  logic                   r_wr_done,   w_wr_done;
  logic                   w_pick_wr;

  // A write wins when no read is waiting or when it has been starved long enough.
  assign w_pick_wr = bus.wr_req && (!bus.rd_req || (r_starve == STARVE_MAX));

  // Next-state and next-output decode; everything holds unless a state acts on it.
  always_comb begin
    w_state    = r_state;
    w_starve   = r_starve;
    w_cnt      = r_cnt;
    w_len      = r_len;
    w_addr     = r_addr;
    w_dir      = r_dir;
    w_rd_grant = r_rd_grant;
    w_wr_grant = r_wr_grant;
    w_enable   = r_enable;
    w_rw       = r_rw;
    w_rd_data  = r_rd_data;
    w_rd_valid = 1'b0;
    w_wr_ack   = 1'b0;
    w_rd_done  = 1'b0;
    w_wr_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_wr) begin
          w_wr_grant = 1'b1;
          w_dir      = 1'b1;
          w_addr     = bus.wr_addr;
          w_len      = bus.wr_len;
          w_cnt      = '0;
          w_starve   = '0;
          w_state    = ARM;
        end else if (bus.rd_req) begin
          w_rd_grant = 1'b1;
          w_dir      = 1'b0;
          w_addr     = bus.rd_addr;
          w_len      = bus.rd_len;
          w_cnt      = '0;
          if (!bus.wr_req)
            w_starve = '0;
          else if (r_starve != STARVE_MAX)
            w_starve = r_starve + 1'b1;
          w_state    = ARM;
        end else if (!bus.wr_req) begin
          w_starve = '0;
        end
      end
      ARM: begin
        w_enable = 1'b1;
        w_rw     = r_dir;
        w_state  = BURST;
      end
      BURST: begin
        if (bus.psram_byte_strobe) begin
          if (r_dir) begin
            w_wr_ack = 1'b1;
          end else begin
            w_rd_valid = 1'b1;
            w_rd_data  = bus.psram_rdata;
          end
          // Compare before incrementing so len = all-ones never wraps the counter.
          if (r_cnt == r_len) begin
            w_cnt    = '0;
            w_enable = 1'b0;
            w_state  = DRAIN;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!bus.psram_busy) begin
          w_rd_grant = 1'b0;
          w_wr_grant = 1'b0;
          w_rw       = 1'b0;
          if (r_dir) w_wr_done = 1'b1;
          else       w_rd_done = 1'b1;
          w_state    = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // State and output registers; async reset drops the burst without a done pulse.
  always_ff @(posedge sysclk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_dir      <= 1'b0;
      r_rd_grant <= 1'b0;
      r_wr_grant <= 1'b0;
      r_enable   <= 1'b0;
      r_rw       <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_done  <= 1'b0;
      r_wr_done  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_starve   <= w_starve;
      r_cnt      <= w_cnt;
      r_len      <= w_len;
      r_addr     <= w_addr;
      r_dir      <= w_dir;
      r_rd_grant <= w_rd_grant;
      r_wr_grant <= w_wr_grant;
      r_enable   <= w_enable;
      r_rw       <= w_rw;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
      r_wr_ack   <= w_wr_ack;
      r_rd_done  <= w_rd_done;
      r_wr_done  <= w_wr_done;
    end
  end

  assign bus.rd_grant      = r_rd_grant;
  assign bus.rd_data       = r_rd_data;
  assign bus.rd_data_valid = r_rd_valid;
  assign bus.rd_done       = r_rd_done;
  assign bus.wr_grant      = r_wr_grant;
  assign bus.wr_data_ack   = r_wr_ack;
  assign bus.wr_done       = r_wr_done;
  assign bus.psram_enable  = r_enable;
  assign bus.psram_rw      = r_rw;
  // Address is latched at grant and stays stable before enable rises.
  assign bus.psram_address = r_addr;
  // Write byte passes straight through, but only while a write owns the controller.
  assign bus.psram_wdata   = r_wr_grant ? bus.wr_data : 8'h00;

endmodule
